// File: rtl/add_sequencer.sv
// add_sequencer: round-robin controller that time-shares one external 1-bit
// full-adder cell among NREQ requesters. Each accepted request is added
// bit-serially, LSB first, over WIDTH cycles with a registered carry. The
// result is then held on a valid/ready response port until it is taken.
module add_sequencer #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [NREQ-1:0]       req_ready,
  output logic                  fa_a,
  output logic                  fa_b,
  output logic                  fa_cin,
  input  logic                  fa_sum,
  input  logic                  fa_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [IDW-1:0]   grant;
  logic             grant_vld;
  logic             accept;
  logic             last_bit;

  // Round-robin search: scan from the far end back toward ptr so that the
  // requester nearest to ptr is the one left standing.
  always_comb begin
    logic [IDW-1:0] idx;
    idx       = '0;
    grant     = ptr_q;
    grant_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr_q + IDW'(k);
      if (req_valid[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  assign accept   = (state_q == S_IDLE) && grant_vld && !rst;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // Control and response registers; reset clears them and drops any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      sum_sh_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      sum_sh_q <= sum_sh_d;
      cout_q   <= cout_d;
    end
  end

  // Operand shifters, running carry and bit counter; always loaded on accept before use.
  always_ff @(posedge clk) begin
    a_sh_q  <= a_sh_d;
    b_sh_q  <= b_sh_d;
    carry_q <= carry_d;
    cnt_q   <= cnt_d;
  end

  // Next-state logic: accept -> WIDTH serial cycles -> hold result until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept)    state_d = S_RUN;
      S_RUN:  if (last_bit)  state_d = S_DONE;
      S_DONE: if (rsp_ready) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // Datapath updates: operand capture on accept, one adder bit per RUN cycle.
  always_comb begin
    ptr_d    = ptr_q;
    id_d     = id_q;
    sum_sh_d = sum_sh_q;
    cout_d   = cout_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_sh_d  = req_a[grant*WIDTH +: WIDTH];
          b_sh_d  = req_b[grant*WIDTH +: WIDTH];
          carry_d = req_cin[grant];
          id_d    = grant;
          cnt_d   = '0;
          ptr_d   = grant + IDW'(1);
        end
      end
      S_RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CW'(1);
        if (last_bit) cout_d = fa_cout;
      end
      default: ;
    endcase
  end

  // Outputs: the adder cell is driven only from registers, and only while running.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready = NREQ'(1) << grant;
    fa_a      = (state_q == S_RUN) ? a_sh_q[0] : 1'b0;
    fa_b      = (state_q == S_RUN) ? b_sh_q[0] : 1'b0;
    fa_cin    = (state_q == S_RUN) ? carry_q   : 1'b0;
    rsp_valid = (state_q == S_DONE);
    rsp_sum   = sum_sh_q;
    rsp_cout  = cout_q;
    rsp_id    = id_q;
    busy      = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_add_sequencer.sv
// tb_add_sequencer: directed scenarios plus a randomized phase for
// add_sequencer. A negedge monitor holds a transaction-level model (who
// should win, what the sum should be, when the result should appear) and
// checks the DUT against a queue of expected results filled at acceptance.
module tb_add_sequencer;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic [NREQ-1:0]       req_ready;
  logic                  fa_a, fa_b, fa_cin, fa_sum, fa_cout;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic [IDW-1:0]        rsp_id;
  logic                  busy;

  add_sequencer #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .req_ready(req_ready),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_id(rsp_id), .busy(busy)
  );

  // External full-adder cell
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic             cout;
    logic [WIDTH-1:0] sum;
  } exp_t;

  exp_t exp_q[$];

  // Monitor model state
  int      phase = 0;   // 0 idle, 1 running, 2 result pending
  int      lat   = 0;
  int      mptr  = 0;
  longint  cur_a, cur_b, cur_cin;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      phase = 0;
      lat   = 0;
      mptr  = 0;
    end else begin
      if (phase == 0) begin
        chk("idle_busy", busy, 0);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_fa", {fa_a, fa_b, fa_cin}, 0);
        if (req_valid != '0) begin
          int g;
          longint tot;
          exp_t e;
          g = -1;
          for (int k = 0; k < NREQ; k++)
            if (g < 0 && req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
          chk("grant", req_ready, 64'(1) << g);
          cur_a   = longint'(req_a[g*WIDTH +: WIDTH]);
          cur_b   = longint'(req_b[g*WIDTH +: WIDTH]);
          cur_cin = longint'(req_cin[g]);
          tot     = cur_a + cur_b + cur_cin;
          e.id    = IDW'(g);
          e.cout  = tot[WIDTH];
          e.sum   = tot[WIDTH-1:0];
          exp_q.push_back(e);
          mptr  = (g + 1) % NREQ;
          phase = 1;
          lat   = 0;
        end else begin
          chk("idle_no_ready", req_ready, 0);
        end
      end else if (phase == 1) begin
        lat++;
        chk("run_busy", busy, 1);
        chk("run_req_ready", req_ready, 0);
        if (lat <= WIDTH) begin
          int     i;
          longint m;
          i = lat - 1;
          m = (longint'(1) << i) - 1;
          chk("run_rsp_valid", rsp_valid, 0);
          chk("fa_a_bit", fa_a, (cur_a >> i) & 1);
          chk("fa_b_bit", fa_b, (cur_b >> i) & 1);
          chk("fa_cin_bit", fa_cin, (((cur_a & m) + (cur_b & m) + cur_cin) >> i) & 1);
        end else begin
          phase = 2;
        end
      end
      if (phase == 2) begin
        chk("done_rsp_valid", rsp_valid, 1);
        chk("done_busy", busy, 1);
        chk("done_req_ready", req_ready, 0);
        chk("done_fa", {fa_a, fa_b, fa_cin}, 0);
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          chk("rsp_sum", rsp_sum, exp_q[0].sum);
          chk("rsp_cout", rsp_cout, exp_q[0].cout);
          chk("rsp_id", rsp_id, exp_q[0].id);
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            phase = 0;
          end
        end
      end
    end
  end

  task automatic set_op(input int i, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic c);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_cin[i]              = c;
  endtask

  // Returns just after the edge on which some requester was accepted.
  task automatic wait_accept(output int g);
    g = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((req_ready & req_valid) != '0) begin
        for (int j = 0; j < NREQ; j++) if (req_ready[j]) g = j;
        break;
      end
    end
    if (g < 0) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Returns just after the edge on which the response handshake completed.
  task automatic wait_rsp(output logic [WIDTH-1:0] s, output logic c, output logic [IDW-1:0] id);
    logic seen;
    seen = 1'b0;
    s = '0; c = 1'b0; id = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        s = rsp_sum; c = rsp_cout; id = rsp_id;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("rsp_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int               g;
    logic [WIDTH-1:0] s;
    logic             c;
    logic [IDW-1:0]   id;
    logic             seen;

    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_sum", rsp_sum, 0);
    chk("reset_rsp_cout", rsp_cout, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_fa", {fa_a, fa_b, fa_cin}, 0);
    req_valid = '0;
    rst       = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single op on requester 0
    set_op(0, 8'hA5, 8'h3C, 1'b0);
    req_valid = 4'b0001;
    wait_accept(g);
    chk("single_grant", g, 0);
    req_valid = '0;
    wait_rsp(s, c, id);
    chk("single_sum", s, 8'hE1);
    chk("single_cout", c, 0);
    chk("single_id", id, 0);

    // Overflow on requester 2
    set_op(2, 8'hFF, 8'h01, 1'b1);
    req_valid = 4'b0100;
    wait_accept(g);
    chk("ovf_grant", g, 2);
    req_valid = '0;
    wait_rsp(s, c, id);
    chk("ovf_sum", s, 8'h01);
    chk("ovf_cout", c, 1);
    chk("ovf_id", id, 2);

    // Requester 3 drops valid right after acceptance; operands scrambled too
    set_op(3, 8'h7E, 8'h81, 1'b1);
    req_valid = 4'b1000;
    wait_accept(g);
    chk("drop_grant", g, 3);
    req_valid = '0;
    set_op(3, 8'h00, 8'h00, 1'b0);
    wait_rsp(s, c, id);
    chk("drop_sum", s, 8'h00);
    chk("drop_cout", c, 1);
    chk("drop_id", id, 3);

    // Fairness: all valid, pointer back at 0
    for (int i = 0; i < NREQ; i++) set_op(i, WIDTH'(8'h11 * (i + 1)), WIDTH'(8'h90 + i * 8'h1D), i[0]);
    req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      wait_accept(g);
      chk("rr_order", g, i % NREQ);
    end
    req_valid = '0;
    wait_rsp(s, c, id);
    chk("rr_last_id", id, 0);

    // Backpressure in DONE with others requesting
    rsp_ready = 1'b0;
    set_op(0, 8'h5A, 8'h5A, 1'b1);
    req_valid = 4'b0001;
    wait_accept(g);
    chk("bp_grant", g, 0);
    req_valid = '1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    chk("bp_reached_done", seen, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_busy", busy, 1);
    chk("bp_req_ready", req_ready, 0);
    chk("bp_sum_held", rsp_sum, 8'hB5);
    rsp_ready = 1'b1;
    wait_rsp(s, c, id);
    chk("bp_sum", s, 8'hB5);
    wait_accept(g);
    chk("bp_next_grant", g, 1);
    req_valid = '0;
    wait_rsp(s, c, id);

    // Reset during RUN at cnt=3
    set_op(2, 8'h33, 8'h44, 1'b0);
    req_valid = 4'b0100;
    wait_accept(g);
    req_valid = '1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp", {rsp_sum, rsp_cout, rsp_id}, 0);
    chk("mid_rst_fa", {fa_a, fa_b, fa_cin}, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    req_valid = '0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_op(1, 8'hC8, 8'h64, 1'b1);
    req_valid = 4'b0010;
    wait_accept(g);
    chk("post_rst_grant", g, 1);
    req_valid = '0;
    wait_rsp(s, c, id);
    chk("post_rst_sum", s, 8'h2D);
    chk("post_rst_cout", c, 1);
    chk("post_rst_id", id, 1);

    // Randomized traffic with random backpressure
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk);
      #1;
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) set_op(i, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (WIDTH + 6) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
